// File: rtl/irom_arbiter.sv
// irom_arbiter: fixed-priority fetch/debug arbiter with starvation guard and response router for a 1-cycle-latency ROM
module irom_arbiter #(
  parameter int ADDR_W = 10,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  output logic              if_err,
  input  logic              dbg_req,
  input  logic [31:0]       dbg_addr,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [31:0]       dbg_rdata,
  output logic              dbg_err,
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_adr,
  input  logic [31:0]       rom_inst
);
  localparam logic [3:0] SMAX = 4'(STARVE_MAX);
  logic resp_valid, resp_owner, resp_err;
  logic [3:0] starve_cnt;
  logic dbg_win, gnt, legal;
  logic [31:0] gaddr;
  always_comb begin
    dbg_win = dbg_req && (!if_req || starve_cnt == SMAX);
    if_gnt = rst_n && if_req && !dbg_win;
    dbg_gnt = rst_n && dbg_win;
    gnt = if_gnt || dbg_gnt;
    gaddr = dbg_win ? dbg_addr : if_addr;
    legal = gaddr[1:0] == 2'b00 && (gaddr >> (ADDR_W + 2)) == 32'd0;
    rom_en = gnt && legal;
    rom_adr = rom_en ? gaddr[ADDR_W+1:2] : '0;
    if_rvalid = resp_valid && !resp_owner;
    dbg_rvalid = resp_valid && resp_owner;
    if_err = if_rvalid && resp_err;
    dbg_err = dbg_rvalid && resp_err;
    if_rdata = (if_rvalid && !resp_err) ? rom_inst : 32'd0;
    dbg_rdata = (dbg_rvalid && !resp_err) ? rom_inst : 32'd0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid <= 1'b0;
      resp_owner <= 1'b0;
      resp_err <= 1'b0;
      starve_cnt <= 4'd0;
    end else begin
      resp_valid <= gnt;
      resp_owner <= dbg_gnt;
      resp_err <= gnt && !legal;
      starve_cnt <= (if_gnt && dbg_req) ? (starve_cnt == SMAX ? SMAX : starve_cnt + 4'd1) : 4'd0;
    end
  end
endmodule

// File: tb/tb_irom_arbiter.sv
// tb_irom_arbiter: directed vectors against a behavioural arbiter/ROM model plus literal spot checks
module tb_irom_arbiter;
  localparam int ADDR_W = 10;
  localparam int STARVE_MAX = 4;
  localparam int WORDS = 1 << ADDR_W;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic if_req = 1'b0, dbg_req = 1'b0;
  logic [31:0] if_addr = 32'd0, dbg_addr = 32'd0;
  logic if_gnt, if_rvalid, if_err, dbg_gnt, dbg_rvalid, dbg_err, rom_en;
  logic [31:0] if_rdata, dbg_rdata;
  logic [ADDR_W-1:0] rom_adr;
  logic [31:0] rom_inst = 32'hDEADBEEF;
  logic [31:0] rom [WORDS];
  int errors = 0;
  int checks = 0;
  logic chk_en = 1'b0;
  int m_starve = 0;
  logic m_pv = 1'b0, m_po = 1'b0, m_pe = 1'b0;
  logic [31:0] m_pd = 32'd0;
  logic [9:0] pat;

  irom_arbiter #(.ADDR_W(ADDR_W), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
    .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata), .dbg_err(dbg_err),
    .rom_en(rom_en), .rom_adr(rom_adr), .rom_inst(rom_inst)
  );

  always #5 clk = ~clk;

  initial for (int i = 0; i < WORDS; i++) rom[i] = 32'hC0DE0000 | i;

  always @(posedge clk) rom_inst <= rom_en ? rom[rom_adr] : 32'hDEADBEEF;

  function automatic logic is_legal(input logic [31:0] a);
    return (a % 4 == 0) && (a / 4 < WORDS);
  endfunction

  function automatic logic dbg_wins();
    return rst_n && dbg_req && (!if_req || m_starve >= STARVE_MAX);
  endfunction

  function automatic logic fetch_wins();
    return rst_n && if_req && !dbg_wins();
  endfunction

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_starve = 0;
      m_pv = 1'b0;
      m_po = 1'b0;
      m_pe = 1'b0;
      m_pd = 32'd0;
    end else begin
      logic f, d;
      logic [31:0] a;
      f = fetch_wins();
      d = dbg_wins();
      a = d ? dbg_addr : if_addr;
      m_pv = f || d;
      m_po = d;
      m_pe = (f || d) && !is_legal(a);
      m_pd = (f || d) && is_legal(a) ? rom[a / 4] : 32'd0;
      m_starve = (f && dbg_req) ? (m_starve + 1 > STARVE_MAX ? STARVE_MAX : m_starve + 1) : 0;
    end
  end

  always @(negedge clk) if (chk_en) begin
    logic f, d, le;
    logic [31:0] a;
    f = fetch_wins();
    d = dbg_wins();
    a = d ? dbg_addr : if_addr;
    le = (f || d) && is_legal(a);
    chk("cyc_if_gnt", 32'(if_gnt), 32'(f));
    chk("cyc_dbg_gnt", 32'(dbg_gnt), 32'(d));
    chk("cyc_rom_en", 32'(rom_en), 32'(le));
    chk("cyc_rom_adr", 32'(rom_adr), le ? a / 4 : 32'd0);
    chk("cyc_if_rvalid", 32'(if_rvalid), 32'(m_pv && !m_po));
    chk("cyc_if_rdata", if_rdata, (m_pv && !m_po) ? m_pd : 32'd0);
    chk("cyc_if_err", 32'(if_err), 32'(m_pv && !m_po && m_pe));
    chk("cyc_dbg_rvalid", 32'(dbg_rvalid), 32'(m_pv && m_po));
    chk("cyc_dbg_rdata", dbg_rdata, (m_pv && m_po) ? m_pd : 32'd0);
    chk("cyc_dbg_err", 32'(dbg_err), 32'(m_pv && m_po && m_pe));
    chk("cyc_one_rvalid", 32'(if_rvalid && dbg_rvalid), 32'd0);
  end

  task automatic step(input logic ir, input logic [31:0] ia, input logic dr, input logic [31:0] da);
    @(posedge clk);
    #1;
    if_req = ir;
    if_addr = ia;
    dbg_req = dr;
    dbg_addr = da;
  endtask

  typedef struct { logic ir; logic [31:0] ia; logic dr; logic [31:0] da; } vec_t;
  vec_t vecs [10] = '{
    '{1'b1, 32'h0000_0ffc, 1'b1, 32'h0000_0004},
    '{1'b1, 32'h0000_0100, 1'b1, 32'h0000_0004},
    '{1'b0, 32'h0, 1'b1, 32'h0000_0ffc},
    '{1'b1, 32'h0000_1000, 1'b0, 32'h0},
    '{1'b1, 32'h8000_0000, 1'b1, 32'h0000_0003},
    '{1'b1, 32'h0000_0200, 1'b1, 32'h0000_0001},
    '{1'b1, 32'h0000_0204, 1'b1, 32'h0000_0002},
    '{1'b1, 32'h0000_0208, 1'b1, 32'h0000_0800},
    '{1'b1, 32'h0000_020c, 1'b1, 32'h0000_0804},
    '{1'b0, 32'h0, 1'b0, 32'h0}
  };

  initial begin
    if_req = 1'b1;
    dbg_req = 1'b1;
    if_addr = 32'h10;
    dbg_addr = 32'h8;
    repeat (2) @(posedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_if_gnt", 32'(if_gnt), 32'd0);
    chk("rst_dbg_gnt", 32'(dbg_gnt), 32'd0);
    chk("rst_rom_en", 32'(rom_en), 32'd0);
    chk("rst_rvalid", 32'(if_rvalid | dbg_rvalid), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    dbg_req = 1'b0;
    @(negedge clk);
    chk("rel_if_gnt", 32'(if_gnt), 32'd1);
    chk("rel_rom_adr", 32'(rom_adr), 32'd4);
    step(1'b0, 32'h0, 1'b0, 32'h0);
    @(negedge clk);
    chk("rel_if_rvalid", 32'(if_rvalid), 32'd1);
    chk("rel_if_rdata", if_rdata, 32'hC0DE0004);
    step(1'b1, 32'h20, 1'b1, 32'h40);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      pat[i] = dbg_gnt;
    end
    chk("starve_pattern", 32'(pat), 32'b10_0001_0000);
    step(1'b1, 32'h0, 1'b0, 32'h0);
    step(1'b0, 32'h0, 1'b1, 32'h8);
    @(negedge clk);
    chk("b2b_if_rvalid", 32'(if_rvalid), 32'd1);
    chk("b2b_if_rdata0", if_rdata, 32'hC0DE0000);
    step(1'b1, 32'h4, 1'b0, 32'h0);
    @(negedge clk);
    chk("b2b_dbg_rvalid", 32'(dbg_rvalid), 32'd1);
    chk("b2b_dbg_rdata2", dbg_rdata, 32'hC0DE0002);
    step(1'b0, 32'h0, 1'b0, 32'h0);
    @(negedge clk);
    chk("b2b_if_rdata1", if_rdata, 32'hC0DE0001);
    step(1'b1, 32'h2, 1'b0, 32'h0);
    @(negedge clk);
    chk("ill_if_gnt", 32'(if_gnt), 32'd1);
    chk("ill_rom_en0", 32'(rom_en), 32'd0);
    step(1'b0, 32'h0, 1'b1, 32'h1000);
    @(negedge clk);
    chk("ill_dbg_gnt", 32'(dbg_gnt), 32'd1);
    chk("ill_rom_en1", 32'(rom_en), 32'd0);
    chk("ill_if_err", 32'(if_err), 32'd1);
    chk("ill_if_rdata", if_rdata, 32'd0);
    step(1'b0, 32'h0, 1'b0, 32'h0);
    @(negedge clk);
    chk("ill_dbg_err", 32'(dbg_err), 32'd1);
    chk("ill_dbg_rdata", dbg_rdata, 32'd0);
    step(1'b0, 32'h0, 1'b1, 32'h8);
    @(negedge clk);
    chk("mid_dbg_gnt", 32'(dbg_gnt), 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    dbg_req = 1'b0;
    @(negedge clk);
    chk("mid_rvalid_in_rst", 32'(dbg_rvalid), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rvalid_rel", 32'(dbg_rvalid), 32'd0);
    step(1'b0, 32'h0, 1'b0, 32'h0);
    @(negedge clk);
    chk("mid_rvalid_after", 32'(dbg_rvalid), 32'd0);
    step(1'b1, 32'h30, 1'b1, 32'h50);
    @(negedge clk);
    chk("wd_no_dbg_gnt", 32'(dbg_gnt), 32'd0);
    step(1'b1, 32'h34, 1'b0, 32'h0);
    @(negedge clk);
    chk("wd_no_dbg_rvalid", 32'(dbg_rvalid), 32'd0);
    step(1'b1, 32'h38, 1'b0, 32'h0);
    @(negedge clk);
    chk("wd_starve_clr", 32'(dut.starve_cnt), 32'd0);
    foreach (vecs[i]) step(vecs[i].ir, vecs[i].ia, vecs[i].dr, vecs[i].da);
    step(1'b0, 32'h0, 1'b0, 32'h0);
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
